// File: rtl/skid_buffer_flush_sync_rstn_if.sv
// Valid/ready handshake bundle for the flushable skid buffer: upstream s_* side and downstream m_* side.
interface skid_buffer_flush_sync_rstn_if #(
  parameter int unsigned WIDTH = 1
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  // Driven by whatever feeds the buffer and drains it.
  modport master (
    output s_valid,
    output s_data,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_data
  );

  // The buffer's own view.
  modport slave (
    input  s_valid,
    input  s_data,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_data
  );
endinterface

// File: rtl/skid_buffer_flush_sync_rstn.sv
// Two-entry registered skid buffer with a single-cycle synchronous flush.
// s_ready is derived from registered state only, so it has no path from m_ready.
module skid_buffer_flush_sync_rstn #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               flush,
  skid_buffer_flush_sync_rstn_if.slave       bus,
  output logic [1:0]                         count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [1:0]       r_count;
  logic [1:0]       w_count_nxt;

  logic             w_s_ready;
  logic             w_m_valid;
  logic             w_in;
  logic             w_out;
  logic             w_ld_main_in;
  logic             w_ld_main_skid;
  logic             w_ld_skid;

  // Handshakes use the internal ready/valid so flush and reset already suppress them.
  assign w_in  = bus.s_valid & w_s_ready;
  assign w_out = w_m_valid & bus.m_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= EMPTY;
      r_count <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in) begin
          w_state_nxt  = BUSY;
          w_ld_main_in = 1'b1;
        end
      end
      BUSY: begin
        case ({w_in, w_out})
          2'b10: begin
            w_state_nxt = FULL;
            w_ld_skid   = 1'b1;
          end
          2'b11: begin
            w_ld_main_in = 1'b1;
          end
          2'b01: begin
            w_state_nxt = EMPTY;
          end
          default: begin
            w_state_nxt = BUSY;
          end
        endcase
      end
      FULL: begin
        if (w_out) begin
          w_state_nxt    = BUSY;
          w_ld_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  always_comb begin
    w_count_nxt = 2'd0;
    case (w_state_nxt)
      BUSY:    w_count_nxt = 2'd1;
      FULL:    w_count_nxt = 2'd2;
      default: w_count_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= bus.s_data;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= bus.s_data;
      end
    end
  end

  always_comb begin
    w_s_ready   = rstn & ~flush & (r_state != FULL);
    w_m_valid   = ~flush & (r_state != EMPTY);
    bus.s_ready = w_s_ready;
    bus.m_valid = w_m_valid;
    bus.m_data  = flush ? '0 : r_main;
    count       = r_count;
  end

endmodule

// File: doc/skid_buffer_flush_sync_rstn.md
# skid_buffer_flush_sync_rstn

Two-entry valid/ready skid buffer with synchronous flush, for pipeline boundaries. Flow control is handshake-driven: the block produces the upstream backpressure (`s_ready`) instead of taking a stall-style enable. It registers the data path and `s_ready` so ready timing paths are cut in both directions. It sustains one beat per cycle. A `flush` input discards all buffered beats in one cycle and forces the outputs to zero while it is asserted.

## Interface
- `WIDTH`, default 1, payload width in bits.

- `clk`  input  1  clock; all state updates on rising edge.
- `rstn`  input  1  reset, synchronous, active-low.
- `flush`  input  1  synchronous discard of all buffered beats; active-high.
- `s_valid`  input  1  upstream beat valid.
- `s_ready`  output  1  upstream beat accepted when `s_valid & s_ready`.
- `s_data`  input  WIDTH  upstream payload.
- `m_valid`  output  1  downstream beat valid.
- `m_ready`  input  1  downstream accepts when `m_valid & m_ready`.
- `m_data`  output  WIDTH  downstream payload.
- `count`  output  2  number of beats held (0..2).

## Operation
- Storage: main register (drives `m_data`) and skid register, each WIDTH bits.
- State machine with states EMPTY (count 0), BUSY (count 1, main valid), FULL (count 2, main and skid valid).
- Handshakes: `in = s_valid & s_ready`, `out = m_valid & m_ready`.
- `s_ready = rstn & ~flush & (state != FULL)`.
- `m_valid = ~flush & (state != EMPTY)`.
- `m_data = flush ? 0 : main`.
- Transitions when `rstn=1` and `flush=0`:
  - EMPTY: on `in`, go to BUSY and load `main <= s_data`. Otherwise stay in EMPTY.
  - BUSY, `in & ~out`: go to FULL and load `skid <= s_data`.
  - BUSY, `in & out`: stay in BUSY and load `main <= s_data`.
  - BUSY, `~in & out`: go to EMPTY.
  - BUSY, neither: hold.
  - FULL, `out`: go to BUSY and load `main <= skid`. `in` is impossible because `s_ready=0`.
  - FULL, no `out`: hold.
- Beats leave in strict arrival order. No beat is duplicated or dropped, except by flush or reset.
- Flush, when `rstn=1`:
  - At the edge, state becomes EMPTY and main and skid are cleared to 0.
  - No beat is accepted or delivered in a flush cycle, even if `s_valid` or `m_ready` is high.
- Reset has priority over flush. With `rstn=0` at an edge: state EMPTY, main=0, skid=0.
- Data registers hold their value when not loaded. An idle `s_data` change has no effect.

## Timing
- Reset values (after the reset edge, with `rstn` high again): `m_valid=0`, `m_data=0`, `count=0`, `s_ready=1`.
- While `rstn=0`: `s_ready=0` combinationally.
- Latency: a beat accepted at edge N is presented on `m_valid`/`m_data` in cycle N+1. This is 1 cycle, with no combinational `s_data`→`m_data` path.
- Throughput: 1 beat/cycle sustained with `m_ready` held high.
- `s_ready` depends only on registered state, `rstn` and `flush`. It has no path from `m_ready`.
- Downstream stall: with `m_ready=0`, at most 2 beats are absorbed. `s_ready` drops in the cycle after the second accept.
- Recovery: the first `out` in FULL raises `s_ready` in the next cycle. The skid beat appears on `m_data` in that same next cycle.
- `flush` forces `m_valid=0`, `m_data=0` and `s_ready=0` in the same cycle, combinationally. Buffer state is clear from the following cycle.
- `count` is registered: EMPTY=0, BUSY=1, FULL=2. `count` is not gated by flush.

## Test plan
- Reset: hold `rstn=0` 3 cycles with `s_valid=1`, `s_data=0xA5` (WIDTH=8) → `s_ready=0`, no accept. After release: `m_valid=0`, `m_data=0`, `count=0`, `s_ready=1`.
- Streaming: send 0x01..0x10 back-to-back with `m_ready=1` → outputs 0x01..0x10 in order, one per cycle, each 1 cycle after accept, `count` stays 1.
- Stall/skid: `m_ready=0`, send 0x11, 0x22, 0x33 → 0x11 and 0x22 accepted, `s_ready=0` after the second, `count=2`. Raise `m_ready` → outputs 0x11, 0x22, 0x33 in order, none lost.
- Flush in FULL: after buffering 0x44, 0x55, assert `flush` for 1 cycle with `m_ready=1`, `s_valid=1` → during flush `m_valid=0`, `m_data=0`, `s_ready=0`. Next cycle `count=0`, and 0x44/0x55 never appear.
- Reset versus flush priority: assert `rstn=0` and `flush=1` together in BUSY → state EMPTY and all data registers 0 after the edge.
- Random: random `s_valid`/`m_ready` for 10k cycles against a reference FIFO model → order preserved, `count` matches the model, and `count` never exceeds 2.
